fir_stream_core: RTL and testbench

FIR_STREAM_CORE -- requirements
Module: fir_stream_core

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_mac.sv | 60 ++++++
 rtl/fir_stream_core.sv | 139 +++++++++++++
 tb/tb_fir_stream_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the streaming FIR core.
//   state_e   - control FSM states (idle, multiply-accumulate, result hold)
//   *Def      - default filter geometry
//   acc_width - full-precision accumulator width for a given geometry
package fir_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StMac,
      StHold
   } state_e;

   localparam int unsigned TapsDef  = 8;
   localparam int unsigned DataWDef = 16;
   localparam int unsigned CoefWDef = 16;
   localparam int unsigned OutWDef  = 32;

   // One product is DATA_W+COEF_W bits; summing TAPS of them grows by log2(TAPS).
   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned coef_w,
                                             input int unsigned taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with saturation to the output width.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, zeroes the accumulator
//   clr_i  - zero the accumulator (sample start or flush)
//   en_i   - add x_i*c_i to the accumulator this cycle
//   x_i    - sample operand
//   c_i    - coefficient operand
//   sat_o  - (acc + x_i*c_i) saturated to signed OUT_W; valid for the last
//            accumulate cycle so the caller can register it on HOLD entry
module fir_mac #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned ACC_W  = 35,
   parameter int unsigned OUT_W  = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic signed [DATA_W-1:0] x_i,
   input  logic signed [COEF_W-1:0] c_i,
   output logic signed [OUT_W-1:0]  sat_o
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  sum;

   assign prod = PROD_W'(x_i) * PROD_W'(c_i);
   assign sum  = acc_q + ACC_W'(prod);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= sum;
      end
   end

   if (ACC_W > OUT_W) begin : g_sat
      // In range iff every bit from the OUT_W sign bit upward agrees.
      logic [ACC_W-OUT_W:0] top_bits;
      assign top_bits = sum[ACC_W-1:OUT_W-1];

      always_comb begin
         if (top_bits == '0 || top_bits == '1) begin
            sat_o = sum[OUT_W-1:0];
         end else if (sum[ACC_W-1]) begin
            sat_o = {1'b1, {(OUT_W-1){1'b0}}};
         end else begin
            sat_o = {1'b0, {(OUT_W-1){1'b1}}};
         end
      end
   end else begin : g_ext
      assign sat_o = OUT_W'(sum);
   end

endmodule

// File: rtl/fir_stream_core.sv
// fir_stream_core: sequential single-MAC FIR filter with stream handshakes.
//   clk, rst_sys             - clock and synchronous active-high reset
//   coef_we/idx/data         - coefficient write port; coef_drop pulses when a
//                              write arrives during MAC and is discarded
//   clear                    - flush delay line/accumulator, abort the sample
//   in_data/valid/ready      - sample input handshake (ready only in IDLE)
//   out_data/valid/ready     - saturated result handshake (valid only in HOLD)
//   busy                     - FSM not in IDLE
module fir_stream_core
   import fir_pkg::*;
#(
   parameter int unsigned TAPS   = TapsDef,
   parameter int unsigned DATA_W = DataWDef,
   parameter int unsigned COEF_W = CoefWDef,
   parameter int unsigned OUT_W  = OutWDef
) (
   input  logic                       clk,
   input  logic                       rst_sys,
   input  logic                       coef_we,
   input  logic [$clog2(TAPS)-1:0]    coef_idx,
   input  logic signed [COEF_W-1:0]   coef_data,
   output logic                       coef_drop,
   input  logic                       clear,
   input  logic signed [DATA_W-1:0]   in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic signed [OUT_W-1:0]    out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy
);

   localparam int unsigned IDX_W = $clog2(TAPS);
   localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, TAPS);

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         tap_q, tap_d;
   logic signed [DATA_W-1:0] x_q [TAPS];
   logic signed [COEF_W-1:0] c_q [TAPS];
   logic signed [OUT_W-1:0]  out_q, out_d;
   logic                     drop_q, drop_d;
   logic                     shift_en, acc_clr, acc_en, coef_wr;
   logic signed [OUT_W-1:0]  sat;

   always_comb begin
      state_d  = state_q;
      tap_d    = tap_q;
      out_d    = out_q;
      shift_en = 1'b0;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;
      drop_d   = coef_we && (state_q == StMac);
      coef_wr  = coef_we && (state_q != StMac);

      if (clear) begin
         // Flush wins over any handshake; a sample offered now is lost.
         state_d = StIdle;
         acc_clr = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  shift_en = 1'b1;
                  acc_clr  = 1'b1;
                  tap_d    = '0;
                  state_d  = StMac;
               end
            end
            StMac: begin
               acc_en = 1'b1;
               tap_d  = tap_q + 1'b1;
               if (tap_q == IDX_W'(TAPS - 1)) begin
                  out_d   = sat;
                  state_d = StHold;
               end
            end
            StHold: begin
               if (out_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_sys) begin
         state_q <= StIdle;
         tap_q   <= '0;
         out_q   <= '0;
         drop_q  <= 1'b0;
         for (int k = 0; k < int'(TAPS); k++) begin
            x_q[k] <= '0;
            c_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         if (clear) begin
            for (int k = 0; k < int'(TAPS); k++) begin
               x_q[k] <= '0;
            end
         end else if (shift_en) begin
            x_q[0] <= in_data;
            for (int k = 1; k < int'(TAPS); k++) begin
               x_q[k] <= x_q[k-1];
            end
         end
         if (coef_wr) begin
            c_q[coef_idx] <= coef_data;
         end
      end
   end

   fir_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
   ) u_mac (
      .clk_i (clk),
      .rst_i (rst_sys),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .x_i   (x_q[tap_q]),
      .c_i   (c_q[tap_q]),
      .sat_o (sat)
   );

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StHold);
   assign busy      = (state_q != StIdle);
   assign out_data  = out_q;
   assign coef_drop = drop_q;

endmodule

// File: tb/tb_fir_stream_core.sv
module tb_fir_stream_core;

   logic        clk = 1'b0;
   logic        rst_sys, coef_we, clear, in_valid, out_ready;
   logic [2:0]  coef_idx;
   logic [15:0] coef_data, in_data;
   logic        coef_drop, in_ready, out_valid, busy;
   logic [31:0] out_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fir_stream_core #(
      .TAPS   (8),
      .DATA_W (16),
      .COEF_W (16),
      .OUT_W  (32)
   ) dut (
      .clk       (clk),
      .rst_sys   (rst_sys),
      .coef_we   (coef_we),
      .coef_idx  (coef_idx),
      .coef_data (coef_data),
      .coef_drop (coef_drop),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input int idx, input logic [15:0] val);
      coef_we   = 1'b1;
      coef_idx  = 3'(idx);
      coef_data = val;
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic send(input logic [15:0] sample);
      in_data  = sample;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Bounded wait for out_valid; a timeout yields X so the caller's check fails.
   task automatic wait_out(output logic [31:0] res);
      int n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      res = (out_valid === 1'b1) ? out_data : 'x;
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run(input logic [15:0] sample, output logic [31:0] res);
      send(sample);
      wait_out(res);
      take_out();
   endtask

   task automatic test_reset();
      rst_sys = 1'b1;
      tick();
      tick();
      rst_sys = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (coef_drop !== 1'b0) begin bad++; $display("FAIL reset_coef_drop got=%0b want=0", coef_drop); end
   endtask

   task automatic test_impulse();
      logic [31:0] res, exp;
      for (int i = 0; i < 8; i++) write_coef(i, 16'(i + 1));
      for (int k = 0; k < 9; k++) begin
         run((k == 0) ? 16'd1 : 16'd0, res);
         exp = (k < 8) ? 32'(k + 1) : 32'd0;
         total++;
         if (res !== exp) begin
            bad++; $display("FAIL impulse_out%0d got=%h want=%h", k, res, exp);
         end
      end
   endtask

   task automatic test_saturation();
      logic [31:0] res;
      for (int i = 0; i < 8; i++) write_coef(i, 16'h7FFF);
      for (int k = 0; k < 8; k++) run(16'h7FFF, res);
      total++; if (res !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_pos got=%h want=7fffffff", res); end
      for (int k = 0; k < 8; k++) run(16'h8000, res);
      total++; if (res !== 32'h80000000) begin bad++; $display("FAIL sat_neg got=%h want=80000000", res); end
   endtask

   task automatic test_latency_backpressure();
      logic [31:0] res;
      int t0;
      clear_pulse();
      for (int i = 0; i < 8; i++) write_coef(i, 16'(i + 1));
      t0 = cyc;
      send(16'd1);
      wait_out(res);
      total++; if (cyc - t0 !== 9) begin bad++; $display("FAIL latency got=%0d want=9", cyc - t0); end
      total++; if (res !== 32'd1) begin bad++; $display("FAIL latency_out got=%h want=1", res); end
      for (int j = 0; j < 5; j++) begin
         total++;
         if (out_data !== 32'd1 || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_c%0d got data=%h rdy=%0b busy=%0b vld=%0b want 1/0/1/1",
                     j, out_data, in_ready, busy, out_valid);
         end
         tick();
      end
      take_out();
      total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL release got busy=%0b rdy=%0b want 0/1", busy, in_ready);
      end
   endtask

   task automatic test_coef_drop();
      logic [31:0] res;
      clear_pulse();
      send(16'd1);
      tick();
      coef_we   = 1'b1;
      coef_idx  = 3'd3;
      coef_data = 16'h0100;
      tick();
      coef_we   = 1'b0;
      total++; if (coef_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%0b want=1", coef_drop); end
      tick();
      total++; if (coef_drop !== 1'b0) begin bad++; $display("FAIL drop_end got=%0b want=0", coef_drop); end
      wait_out(res);
      take_out();
      total++; if (res !== 32'd1) begin bad++; $display("FAIL drop_out0 got=%h want=1", res); end
      for (int k = 0; k < 3; k++) begin
         run(16'd0, res);
         total++;
         if (res !== 32'(k + 2)) begin
            bad++; $display("FAIL drop_out%0d got=%h want=%h", k + 1, res, 32'(k + 2));
         end
      end
   endtask

   task automatic test_abort(input bit use_rst);
      logic [31:0] res, exp;
      int seen = 0;
      clear_pulse();
      write_coef(0, 16'd2);
      send(16'd7);
      tick();
      tick();
      tick();
      if (use_rst) rst_sys = 1'b1; else clear = 1'b1;
      tick();
      rst_sys = 1'b0;
      clear   = 1'b0;
      total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL abort%0d_state got busy=%0b rdy=%0b vld=%0b want 0/1/0",
                         use_rst, busy, in_ready, out_valid);
      end
      for (int j = 0; j < 12; j++) begin
         if (out_valid === 1'b1) seen++;
         tick();
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort%0d_no_out got=%0d want=0", use_rst, seen); end
      run(16'd5, res);
      exp = use_rst ? 32'd0 : 32'd10;
      total++; if (res !== exp) begin bad++; $display("FAIL abort%0d_next got=%h want=%h", use_rst, res, exp); end
   endtask

   initial begin
      rst_sys   = 1'b1;
      coef_we   = 1'b0;
      coef_idx  = '0;
      coef_data = '0;
      clear     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_impulse();
      test_saturation();
      test_latency_backpressure();
      test_coef_drop();
      test_abort(1'b0);
      test_abort(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
